// File: rtl/adder_pkg.sv
// adder_pkg: shared operation encoding and add/subtract helper for the pipelined adder
package adder_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} add_op_e;
  localparam int MAX_W = 64;
  // w-bit operands zero-extended to MAX_W; result kept to w+1 bits (carry or borrow in the top bit)
  function automatic logic [MAX_W:0] add_sub(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                             input add_op_e op, input int w);
    logic [MAX_W:0] r;
    r = (op == OP_SUB) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    return r & ~({(MAX_W + 1){1'b1}} << (w + 1));
  endfunction
endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one valid/data register that loads whenever it is empty or its contents move on
module adder_pipe_stage #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         down_ready,
  output logic         load,
  output logic         valid,
  output logic [W-1:0] data
);
  assign load = !valid || down_ready;
  // capture upstream beat (or a bubble) when allowed; data only changes on a real beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: unsigned add/subtract through a STAGES-deep valid/ready pipeline with occupancy count
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int STAGES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            data_in0,
  input  logic [WIDTH-1:0]            data_in1,
  input  logic                        op_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH:0]              data_out,
  output logic [$clog2(STAGES+1)-1:0] inflight
);
  localparam int CW = $clog2(STAGES + 1);
  logic [STAGES:0] v;
  logic [STAGES:0] rdy;
  logic [WIDTH:0]  d [STAGES+1];
  logic [MAX_W:0]  r;
  logic            unused_hi;
  logic            acc;
  logic            cons;
  assign r         = add_sub(MAX_W'(data_in0), MAX_W'(data_in1), add_op_e'(op_sub), WIDTH);
  assign unused_hi = ^r[MAX_W:WIDTH+1];
  assign v[0]        = in_valid;
  assign d[0]        = r[WIDTH:0];
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v[STAGES];
  assign data_out    = d[STAGES];
  assign acc         = in_valid && rdy[0];
  assign cons        = v[STAGES] && out_ready;
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    adder_pipe_stage #(.W(WIDTH + 1)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .up_valid  (v[i]),
      .up_data   (d[i]),
      .down_ready(rdy[i+1]),
      .load      (rdy[i]),
      .valid     (v[i+1]),
      .data      (d[i+1])
    );
  end
  // occupancy: +1 per accepted beat, -1 per consumed beat, net zero when both happen
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inflight <= '0;
    else inflight <= inflight + CW'(acc) - CW'(cons);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of a 3-stage and a 1-stage pipelined adder
module tb_pipelined_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v3 = 1'b0, s3 = 1'b0, or3 = 1'b1, r3, ov3;
  logic [8:0] a3 = '0, b3 = '0;
  logic [9:0] d3;
  logic [1:0] f3;
  logic       v1 = 1'b0, s1 = 1'b0, or1 = 1'b1, r1, ov1;
  logic [8:0] a1 = '0, b1 = '0;
  logic [9:0] d1;
  logic [0:0] f1;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(9), .STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .data_in0(a3), .data_in1(b3),
    .op_sub(s3), .out_valid(ov3), .out_ready(or3), .data_out(d3), .inflight(f3));

  pipelined_adder #(.WIDTH(9), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .data_in0(a1), .data_in1(b1),
    .op_sub(s1), .out_valid(ov1), .out_ready(or1), .data_out(d1), .inflight(f1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [8:0] a, input logic [8:0] b, input logic sub);
    v3 = 1'b1; a3 = a; b3 = b; s3 = sub;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov3); end
    n_chk++; if (d3 !== 10'd0) begin n_fail++; $display("FAIL reset_data_out: got %0d want 0", d3); end
    n_chk++; if (f3 !== 2'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", f3); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (r3 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", r3); end
  endtask

  task automatic test_add;
    or3 = 1'b1;
    drive3(9'd511, 9'd511, 1'b0);
    tick;
    v3 = 1'b0;
    n_chk++; if (f3 !== 2'd1) begin n_fail++; $display("FAIL add_inflight_one: got %0d want 1", f3); end
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL add_early_valid_e0: got %b want 0", ov3); end
    tick;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL add_early_valid_e1: got %b want 0", ov3); end
    tick;
    n_chk++; if (ov3 !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b want 1", ov3); end
    n_chk++; if (d3 !== 10'd1022) begin n_fail++; $display("FAIL add_sum: got %0d want 1022", d3); end
    tick;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL add_drain_valid: got %b want 0", ov3); end
    n_chk++; if (f3 !== 2'd0) begin n_fail++; $display("FAIL add_drain_inflight: got %0d want 0", f3); end
  endtask

  task automatic test_sub;
    drive3(9'd5, 9'd7, 1'b1);
    tick;
    drive3(9'd7, 9'd5, 1'b1);
    tick;
    v3 = 1'b0;
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'h3FE) begin n_fail++; $display("FAIL sub_borrow: got v=%b %h want v=1 3fe", ov3, d3); end
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'h002) begin n_fail++; $display("FAIL sub_plain: got v=%b %h want v=1 002", ov3, d3); end
    tick;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL sub_drain: got %b want 0", ov3); end
  endtask

  task automatic test_backpressure;
    or3 = 1'b0;
    drive3(9'd1, 9'd2, 1'b0);
    tick;
    drive3(9'd3, 9'd4, 1'b0);
    tick;
    drive3(9'd5, 9'd6, 1'b0);
    tick;
    drive3(9'd7, 9'd8, 1'b0);
    #1;
    n_chk++; if (r3 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", r3); end
    n_chk++; if (f3 !== 2'd3) begin n_fail++; $display("FAIL bp_full_inflight: got %0d want 3", f3); end
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd3) begin n_fail++; $display("FAIL bp_head: got v=%b %0d want v=1 3", ov3, d3); end
    tick;
    n_chk++; if (d3 !== 10'd3 || f3 !== 2'd3) begin n_fail++; $display("FAIL bp_hold: got %0d/%0d want 3/3", d3, f3); end
    or3 = 1'b1;
    #1;
    n_chk++; if (r3 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb: got %b want 1", r3); end
    tick;
    v3 = 1'b0;
    n_chk++; if (d3 !== 10'd7 || f3 !== 2'd3) begin n_fail++; $display("FAIL bp_out2: got %0d/%0d want 7/3", d3, f3); end
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd11) begin n_fail++; $display("FAIL bp_out3: got v=%b %0d want v=1 11", ov3, d3); end
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd15) begin n_fail++; $display("FAIL bp_out4: got v=%b %0d want v=1 15", ov3, d3); end
    tick;
    n_chk++; if (ov3 !== 1'b0 || f3 !== 2'd0) begin n_fail++; $display("FAIL bp_empty: got v=%b n=%0d want v=0 n=0", ov3, f3); end
  endtask

  task automatic test_bubble;
    or3 = 1'b0;
    drive3(9'd10, 9'd20, 1'b0);
    tick;
    v3 = 1'b0;
    tick;
    drive3(9'd1, 9'd1, 1'b0);
    tick;
    v3 = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    n_chk++; if (f3 !== 2'd2) begin n_fail++; $display("FAIL bubble_inflight: got %0d want 2", f3); end
    n_chk++; if (r3 !== 1'b1) begin n_fail++; $display("FAIL bubble_ready: got %b want 1", r3); end
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd30) begin n_fail++; $display("FAIL bubble_head: got v=%b %0d want v=1 30", ov3, d3); end
    or3 = 1'b1;
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd2) begin n_fail++; $display("FAIL bubble_second: got v=%b %0d want v=1 2", ov3, d3); end
    tick;
    n_chk++; if (ov3 !== 1'b0 || f3 !== 2'd0) begin n_fail++; $display("FAIL bubble_empty: got v=%b n=%0d want v=0 n=0", ov3, f3); end
  endtask

  task automatic test_reset_mid;
    or3 = 1'b0;
    drive3(9'd1, 9'd1, 1'b0);
    tick;
    drive3(9'd2, 9'd2, 1'b0);
    tick;
    v3 = 1'b0;
    tick;
    n_chk++; if (ov3 !== 1'b1 || d3 !== 10'd2 || f3 !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre: got v=%b %0d n=%0d want v=1 2 n=2", ov3, d3, f3); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (ov3 !== 1'b0 || d3 !== 10'd0 || f3 !== 2'd0) begin n_fail++; $display("FAIL rstmid_async: got v=%b %0d n=%0d want v=0 0 n=0", ov3, d3, f3); end
    #2;
    rst_n = 1'b1;
    or3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost%0d: got %b want 0", k, ov3); end
    end
  endtask

  task automatic test_back_to_back;
    or1 = 1'b1;
    v1 = 1'b1; a1 = 9'd100; b1 = 9'd200; s1 = 1'b0;
    #1;
    n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", r1); end
    tick;
    n_chk++; if (ov1 !== 1'b1 || d1 !== 10'd300) begin n_fail++; $display("FAIL b2b_out0: got v=%b %0d want v=1 300", ov1, d1); end
    a1 = 9'd0; b1 = 9'd0;
    n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", r1); end
    tick;
    n_chk++; if (ov1 !== 1'b1 || d1 !== 10'd0) begin n_fail++; $display("FAIL b2b_out1: got v=%b %0d want v=1 0", ov1, d1); end
    a1 = 9'd511; b1 = 9'd1;
    n_chk++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", r1); end
    tick;
    n_chk++; if (ov1 !== 1'b1 || d1 !== 10'd512) begin n_fail++; $display("FAIL b2b_out2: got v=%b %0d want v=1 512", ov1, d1); end
    n_chk++; if (f1 !== 1'd1) begin n_fail++; $display("FAIL b2b_inflight: got %0d want 1", f1); end
    v1 = 1'b0;
    tick;
    n_chk++; if (ov1 !== 1'b0 || f1 !== 1'd0) begin n_fail++; $display("FAIL b2b_drain: got v=%b n=%0d want v=0 n=0", ov1, f1); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_backpressure;
    test_bubble;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
